// File: rtl/i2c_read_scheduler.sv
// Read-side sequencer for the I2C peripheral: selects a byte source by address,
// feeds the byte transmitter one byte at a time and handles the master's ACK/NACK slot.
module i2c_read_scheduler #(
    parameter int MAX_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        txn_start,
    input  logic [6:0]  txn_addr,
    input  logic        sda_in,
    input  logic [23:0] src_data,
    output logic [2:0]  src_pop,
    output logic [7:0]  tx_byte,
    output logic        tx_load,
    output logic        tx_enable,
    output logic [7:0]  direction,
    output logic        busy,
    output logic        done,
    output logic        nacked,
    output logic        bad_addr,
    output logic [3:0]  bytes_sent
);
    localparam logic [7:0] DIR_DRIVE = 8'h20;
    localparam logic [3:0] MAX_COUNT = 4'(MAX_BYTES);
    localparam logic [6:0] SRC_ADDR [3] = '{7'h2A, 7'h55, 7'h3F};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_ACK,
        ST_DONE,
        ST_BAD
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  sel_reg, sel_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [3:0]  bytes_sent_reg, bytes_sent_next, bytes_inc;
    logic        nacked_reg, nacked_next;

    logic [2:0]  src_pop_reg, src_pop_next;
    logic [7:0]  tx_byte_reg, tx_byte_next;
    logic        tx_load_reg, tx_enable_reg, busy_reg, done_reg, bad_addr_reg;
    logic [7:0]  direction_reg;

    logic [2:0]  addr_hit;
    logic [7:0]  src_byte [3];
    logic [7:0]  byte_sel;

    for (genvar gi = 0; gi < 3; gi++) begin : g_src
        assign addr_hit[gi]     = (txn_addr == SRC_ADDR[gi]);
        assign src_byte[gi]     = src_data[gi*8 +: 8];
        assign src_pop_next[gi] = (state_next == ST_LOAD) && sel_next[gi];
    end

    always_comb begin
        byte_sel = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (sel_next[i]) begin
                byte_sel = byte_sel | src_byte[i];
            end
        end
    end

    assign bytes_inc = (bytes_sent_reg == 4'hF) ? 4'hF : bytes_sent_reg + 4'd1;

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        bit_cnt_next    = bit_cnt_reg;
        bytes_sent_next = bytes_sent_reg;
        nacked_next     = nacked_reg;
        case (state_reg)
            ST_IDLE: begin
                if (txn_start) begin
                    if (|addr_hit) begin
                        sel_next        = addr_hit;
                        bytes_sent_next = 4'd0;
                        nacked_next     = 1'b0;
                        state_next      = ST_LOAD;
                    end else begin
                        state_next = ST_BAD;
                    end
                end
            end
            ST_LOAD: begin
                bit_cnt_next = 3'd0;
                state_next   = ST_SHIFT;
            end
            ST_SHIFT: begin
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                bytes_sent_next = bytes_inc;
                if (sda_in) begin
                    nacked_next = 1'b1;
                    state_next  = ST_DONE;
                end else if (bytes_inc < MAX_COUNT) begin
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_BAD:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The byte is captured on the edge entering LOAD so it is stable for the whole load strobe.
    assign tx_byte_next = (state_next == ST_LOAD) ? byte_sel : tx_byte_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= 3'b000;
            bit_cnt_reg    <= 3'd0;
            bytes_sent_reg <= 4'd0;
            nacked_reg     <= 1'b0;
            src_pop_reg    <= 3'b000;
            tx_byte_reg    <= 8'h00;
            tx_load_reg    <= 1'b0;
            tx_enable_reg  <= 1'b0;
            direction_reg  <= 8'h00;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            bad_addr_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            bit_cnt_reg    <= bit_cnt_next;
            bytes_sent_reg <= bytes_sent_next;
            nacked_reg     <= nacked_next;
            src_pop_reg    <= src_pop_next;
            tx_byte_reg    <= tx_byte_next;
            tx_load_reg    <= (state_next == ST_LOAD);
            tx_enable_reg  <= (state_next == ST_SHIFT);
            direction_reg  <= ((state_next == ST_LOAD) || (state_next == ST_SHIFT)) ? DIR_DRIVE : 8'h00;
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_DONE);
            bad_addr_reg   <= (state_next == ST_BAD);
        end
    end

    assign src_pop    = src_pop_reg;
    assign tx_byte    = tx_byte_reg;
    assign tx_load    = tx_load_reg;
    assign tx_enable  = tx_enable_reg;
    assign direction  = direction_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign nacked     = nacked_reg;
    assign bad_addr   = bad_addr_reg;
    assign bytes_sent = bytes_sent_reg;
endmodule

// File: doc/i2c_read_scheduler.md
# i2c_read_scheduler

Sequencer for the read side of the I2C peripheral. After the address phase has decoded a read request, it selects the peripheral byte source by 7-bit address. It then drives the shared byte transmitter one byte at a time and releases SDA for the master's ACK slot after each byte. The transaction continues until the master NACKs or a byte limit is reached. It sits between the address/RW decoder and the byte transmitter/output mux, and owns the `direction` mask.

## Interface
- `MAX_BYTES`, default 4: bytes per transaction before forced end; legal range 1..15.
- `clk  in  1`: SCL-derived clock; all logic on rising edge.
- `rst_n  in  1`: synchronous reset, active-low.
- `txn_start  in  1`: one-cycle pulse; address phase complete with RW=read.
- `txn_addr  in  7`: decoded device address; sampled on the `txn_start` cycle.
- `sda_in  in  1`: sampled SDA; 0 = ACK, 1 = NACK during the ACK slot.
- `src_data  in  24`: byte sources.
  - [7:0] = source 0 (addr 0x2A).
  - [15:8] = source 1 (addr 0x55).
  - [23:16] = source 2 (addr 0x3F).
- `src_pop  out  3`: one-hot pulse; the selected source's byte has been consumed.
- `tx_byte  out  8`: byte for the transmitter shift register.
- `tx_load  out  1`: one-cycle load strobe for `tx_byte`.
- `tx_enable  out  1`: transmitter shift enable.
- `direction  out  8`: pad output-enable mask.
  - 8'h20 while driving SDA.
  - 8'h00 otherwise.
- `busy  out  1`: high in any state except IDLE.
- `done  out  1`: one-cycle pulse at transaction end.
- `nacked  out  1`: high if the last transaction ended on NACK; held until next `txn_start` accepted.
- `bad_addr  out  1`: one-cycle pulse on an unmapped address.
- `bytes_sent  out  4`: bytes acknowledged-or-ended in the current/last transaction.

## Operation
- States: IDLE, LOAD, SHIFT, ACK, DONE, BAD. All outputs are registered. The values below are those held while in each state.
- IDLE:
  - Outputs: all strobes 0, `direction`=8'h00.
  - `txn_start`=1 with `txn_addr` ∈ {0x2A, 0x55, 0x3F}:
    - Latch source select.
    - `bytes_sent`<=0, `nacked`<=0.
    - Next state LOAD.
  - `txn_start`=1 with any other address, including 0x00: next state BAD.
- LOAD (1 cycle):
  - `tx_byte` = selected `src_data` byte.
  - `tx_load`=1, `src_pop`[sel]=1, `direction`=8'h20.
  - Clear bit counter; next state SHIFT.
- SHIFT (exactly 8 cycles):
  - `tx_enable`=1, `direction`=8'h20.
  - 3-bit bit counter increments each cycle.
  - After counter value 7, next state ACK.
- ACK (1 cycle):
  - `direction`=8'h00, `tx_enable`=0.
  - `sda_in` is sampled at the edge ending the cycle.
  - `bytes_sent` increments, saturating at 15.
  - `sda_in`=1: `nacked`<=1, next state DONE.
  - `sda_in`=0 and the incremented `bytes_sent` < `MAX_BYTES`: next state LOAD, same source.
  - `sda_in`=0 and the incremented `bytes_sent` == `MAX_BYTES`: next state DONE.
- DONE (1 cycle): `done`=1, then IDLE.
- BAD (1 cycle): `bad_addr`=1, `direction`=8'h00, no `tx_load`/`src_pop`, then IDLE.
- `txn_start` outside IDLE is ignored; no queuing.
- `txn_addr` changes after acceptance are ignored.
- `src_data` is sampled only in LOAD; sources must present the next byte by the next LOAD (≥9 cycles after `src_pop`).

## Timing
- Reset (`rst_n`=0 at an edge):
  - State IDLE.
  - `tx_byte`=8'h00, `src_pop`=0, `tx_load`=0, `tx_enable`=0.
  - `direction`=8'h00, `busy`=0, `done`=0, `nacked`=0, `bad_addr`=0, `bytes_sent`=0.
  - Reset mid-transaction aborts immediately: no `done` pulse, SDA released the next cycle.
- `txn_start` sampled at edge E0:
  - LOAD during cycle E0..E1.
  - `tx_enable` high E1..E9.
  - ACK slot E9..E10.
  - Next LOAD or DONE from E10.
- Per-byte period: 10 cycles (1 LOAD + 8 SHIFT + 1 ACK).
- `done` is asserted one cycle after the final ACK slot.
- `busy` deasserts on the cycle after DONE/BAD.
- Minimum spacing between accepted transactions: 2 cycles after `done`; `txn_start` coincident with the DONE cycle is ignored.

## Test plan
- Read 0x2A, `src_data`[7:0]=8'hAA, master ACK, ACK, NACK:
  - Exactly 3 `tx_load` pulses, each followed by 8 `tx_enable` cycles.
  - `src_pop`=3'b001 ×3.
  - `done` at cycle 31 after `txn_start`.
  - `bytes_sent`=3, `nacked`=1.
- Read 0x55, `MAX_BYTES`=4, master always ACK:
  - 4 bytes, `tx_byte`=`src_data`[15:8] each time.
  - `done` after the 4th ACK slot.
  - `nacked`=0, `bytes_sent`=4.
- `txn_addr`=0x11 and 0x00:
  - `bad_addr` pulses 1 cycle after `txn_start`.
  - No `tx_load`/`src_pop`, `direction` stays 8'h00, returns to IDLE.
- Read 0x3F, pulse `txn_start` with addr 0x2A during SHIFT: ignored; `src_pop` remains 3'b100 for the whole transaction.
- `rst_n`=0 at SHIFT bit 4 of byte 2: next cycle all outputs at reset values; a subsequent `txn_start` (0x2A) runs normally from byte 1.
- Direction check: `direction`=8'h20 exactly during LOAD+SHIFT and 8'h00 in every ACK slot, across a 2-byte transaction.
